// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage data access block.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte offset of a 32-bit word within the address.
  localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/data/valid store: combinational read, registered write, sync valid clear.
// Zero-latency read, write lands on the next edge; no backpressure.
module dcache_array
  import mem_access_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 32 - INDEX_BITS - WORD_OFFSET
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic                  we_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [31:0]           wr_dat_i,
  output logic                  rd_vld_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [31:0]           rd_dat_o
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: valid gates every use.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= wr_tag_i;
      data_q[idx_i] <= wr_dat_i;
    end
  end

  assign rd_vld_o = valid_q[idx_i];
  assign rd_tag_o = tag_q[idx_i];
  assign rd_dat_o = data_q[idx_i];

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: zero-stall load hits, otherwise IDLE->REQ->DONE over a req/ack memory port.
// Stalls the pipeline from the missing cycle until ack; cache built only with MEM_ACCESS_CACHE_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        memStall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int          TAG_BITS  = 32 - INDEX_BITS - WORD_OFFSET;
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << WORD_OFFSET) - 32'd1);

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        access;
  logic        is_store;
  logic        hit;
  logic [31:0] line_dat;

  assign access   = MemRead_i | MemWrite_i;
  assign is_store = MemWrite_i;

`ifdef MEM_ACCESS_CACHE_EN
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [TAG_BITS-1:0]   line_tag;
  logic                  line_vld;
  logic                  arr_we;

  assign idx = Addr_i[INDEX_BITS+WORD_OFFSET-1:WORD_OFFSET];
  assign tag = Addr_i[31:INDEX_BITS+WORD_OFFSET];
  assign hit = line_vld && (line_tag == tag);

  // Load misses allocate; stores only refresh a line they already hit.
  assign arr_we = !rst_i && (state_q == ST_REQ) && mem_ack_i && (!is_store || hit);

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_dcache_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .idx_i    (idx),
    .we_i     (arr_we),
    .wr_tag_i (tag),
    .wr_dat_i (is_store ? WriteData_i : mem_rdata_i),
    .rd_vld_o (line_vld),
    .rd_tag_o (line_tag),
    .rd_dat_o (line_dat)
  );
`else
  assign hit      = 1'b0;
  assign line_dat = '0;
`endif

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    ReadData_o  = '0;
    memStall_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (!is_store && hit) begin
            ReadData_o = line_dat;
          end else begin
            memStall_o = 1'b1;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        mem_req_o   = 1'b1;
        memStall_o  = 1'b1;
        mem_we_o    = is_store;
        mem_addr_o  = Addr_i & ADDR_MASK;
        mem_wdata_o = WriteData_i;
        if (mem_ack_i) begin
          state_d  = ST_DONE;
          result_d = is_store ? '0 : mem_rdata_i;
        end
      end
      ST_DONE: begin
        // Inputs here still describe the served access, so never re-arm from DONE.
        ReadData_o = result_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst_i) begin
      state_d     = ST_IDLE;
      result_d    = '0;
      ReadData_o  = '0;
      memStall_o  = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access; expectations follow MEM_ACCESS_CACHE_EN when defined.
module tb_mem_access;

`ifdef MEM_ACCESS_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] Addr_i, WriteData_i;
  logic [31:0] ReadData_o;
  logic        memStall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_access #(.INDEX_BITS(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .Addr_i      (Addr_i),
    .WriteData_i (WriteData_i),
    .ReadData_o  (ReadData_o),
    .memStall_o  (memStall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    int          stalls;
    int          reqs;
    logic        we;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];

  // Reference direct-mapped cache: index addr[5:2], tag addr[31:6].
  bit          m_vld [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_dat [16];

  function automatic void model_clear();
    foreach (m_vld[i]) m_vld[i] = 1'b0;
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, " idle stall"}, {31'd0, memStall_o}, 32'd0);
    check_val({tag, " idle req"},   {31'd0, mem_req_o},  32'd0);
    check_val({tag, " idle rdata"}, ReadData_o,          32'd0);
    check_val({tag, " idle addr"},  mem_addr_o,          32'd0);
  endtask

  // Drive one access; memory acks in REQ cycle number ack_at (1 = first).
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_at,
                            input logic [31:0] rdata, input string tag);
    exp_t        e, got_e;
    logic [3:0]  idx;
    logic [25:0] tg;
    logic        mhit;
    int          stalls, reqs;
    logic        we_seen, done;
    logic [31:0] addr_seen, rd_seen;

    idx  = addr[5:2];
    tg   = addr[31:6];
    mhit = CACHE_ON && m_vld[idx] && (m_tag[idx] == tg);
    if (!wr && mhit) begin
      e.rdata = m_dat[idx]; e.stalls = 0; e.reqs = 0; e.we = 1'b0; e.addr = 32'd0;
    end else begin
      e.rdata  = wr ? 32'd0 : rdata;
      e.stalls = ack_at + 1;       // the IDLE decision cycle plus every REQ cycle
      e.reqs   = ack_at;
      e.we     = wr;
      e.addr   = {addr[31:2], 2'b00};
    end
    sb_q.push_back(e);
    if (CACHE_ON) begin
      if (wr && mhit) m_dat[idx] = wdata;
      else if (!wr && !mhit) begin
        m_vld[idx] = 1'b1; m_tag[idx] = tg; m_dat[idx] = rdata;
      end
    end

    @(negedge clk_i);
    MemRead_i = rd; MemWrite_i = wr; Addr_i = addr; WriteData_i = wdata;
    stalls = 0; reqs = 0; we_seen = 1'b0; addr_seen = 32'd0; rd_seen = 32'd0; done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
      if (mem_req_o) begin
        reqs++;
        we_seen   = mem_we_o;
        addr_seen = mem_addr_o;
        if (reqs == ack_at) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = rdata;
        end
      end
      if (memStall_o) stalls++;
      else begin
        done    = 1'b1;
        rd_seen = ReadData_o;
      end
    end
    MemRead_i = 1'b0; MemWrite_i = 1'b0; Addr_i = '0; WriteData_i = '0; mem_ack_i = 1'b0;
    check_val({tag, " completed"}, {31'd0, done}, 32'd1);
    if (sb_q.size() == 0) begin
      check_val({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      got_e = sb_q.pop_front();
      check_val({tag, " rdata"},  rd_seen,          got_e.rdata);
      check_val({tag, " stalls"}, 32'(stalls),      32'(got_e.stalls));
      check_val({tag, " reqs"},   32'(reqs),        32'(got_e.reqs));
      check_val({tag, " we"},     {31'd0, we_seen}, {31'd0, got_e.we});
      check_val({tag, " addr"},   addr_seen,        got_e.addr);
    end
    @(negedge clk_i);
    #1;
    check_idle(tag);
  endtask

  initial begin
    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; Addr_i = '0; WriteData_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    model_clear();
    repeat (2) @(negedge clk_i);
    #1;
    check_val("reset stall", {31'd0, memStall_o}, 32'd0);
    check_val("reset req",   {31'd0, mem_req_o},  32'd0);
    check_val("reset rdata", ReadData_o,          32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_idle("post-reset");

    run_access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, "load 0x100 first");
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'h0BADF00D, "load 0x100 repeat");
    run_access(1'b0, 1'b1, 32'h100, 32'h12345678, 1, 32'h0, "store 0x100");
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h55555555, "load after store");
    run_access(1'b1, 1'b0, 32'h140, 32'h0, 2, 32'hA5A5A5A5, "load 0x140 conflict");
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h11112222, "load 0x100 evicted");
    run_access(1'b0, 1'b1, 32'h300, 32'hCCCC0000, 2, 32'h0, "store miss 0x300");
    run_access(1'b1, 1'b0, 32'h300, 32'h0, 1, 32'h0000C0DE, "load 0x300 no-alloc");

    // Reset lands in the second REQ cycle together with an ack.
    @(negedge clk_i);
    MemRead_i = 1'b1; Addr_i = 32'h100;
    @(negedge clk_i);
    #1;
    check_val("midreq first req", {31'd0, mem_req_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    #1;
    check_val("midreq rst stall", {31'd0, memStall_o}, 32'd0);
    check_val("midreq rst req",   {31'd0, mem_req_o},  32'd0);
    check_val("midreq rst rdata", ReadData_o,          32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; MemRead_i = 1'b0; Addr_i = '0;
    model_clear();
    #1;
    check_idle("after midreq rst");
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    check_idle("late ack ignored");
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'h33334444, "load after rst");

    run_access(1'b1, 1'b1, 32'h200, 32'h00000077, 2, 32'hFFFFFFFF, "rd+wr 0x200");
    run_access(1'b1, 1'b0, 32'h203, 32'h0, 1, 32'h9ABCDEF0, "load 0x203 aligned");

    if (sb_q.size() != 0) check_val("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
